// File: rtl/duzen_cnt_mod.sv
// duzen_cnt_mod: synchronous modulo-N decimal digit counter with up/down,
// clear, clamped parallel load, cascade carry/borrow and 7-segment decoder.
// Optional build macro DUZEN_BLANK_ZERO_EN: when defined, BLANK=1 with Q==0
// drives all segments dark (leading-zero suppression); otherwise BLANK is ignored.
module duzen_cnt_mod #(
   parameter int unsigned MODULO         = 6,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       EN,
   input  logic       DOWN,
   input  logic       CLR,
   input  logic       LOAD,
   input  logic [3:0] LD_VAL,
   input  logic       BLANK,
   output logic [3:0] Q,
   output logic       CLK_OUT,
   output logic       ADS,
   output logic       BDS,
   output logic       CDS,
   output logic       DDS,
   output logic       EDS,
   output logic       FDS,
   output logic       GDS
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned SEG_W   = 7;
   localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MODULO - 1);

   logic [CNT_W-1:0] q_nxt;
   logic [SEG_W-1:0] lit_c;
   logic [SEG_W-1:0] seg_c;
   logic             blank_c;

   // Count register; reset forces the digit to zero regardless of the clock.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Q <= '0;
      end else begin
         Q <= q_nxt;
      end
   end

   // Next count: clear beats load beats count; loads above range clamp to the top digit.
   always_comb begin
      q_nxt = Q;
      if (CLR) begin
         q_nxt = '0;
      end else if (LOAD) begin
         q_nxt = (LD_VAL > MAX_VAL) ? MAX_VAL : LD_VAL;
      end else if (EN) begin
         if (DOWN) begin
            q_nxt = (Q == '0) ? MAX_VAL : (Q - CNT_W'(1));
         end else begin
            q_nxt = (Q == MAX_VAL) ? '0 : (Q + CNT_W'(1));
         end
      end
   end

   // Terminal-count strobe so the next stage advances on the same edge as this wrap.
   always_comb begin
      CLK_OUT = 1'b0;
      if (RST_N && EN && !CLR && !LOAD) begin
         CLK_OUT = DOWN ? (Q == '0) : (Q == MAX_VAL);
      end
   end

`ifdef DUZEN_BLANK_ZERO_EN
   assign blank_c = BLANK & (Q == '0);
`else
   logic unused_blank;
   assign unused_blank = BLANK;
   assign blank_c      = 1'b0;
`endif

   // Digit to lit-segment pattern, bit order {a,b,c,d,e,f,g}; codes above 9 stay dark.
   always_comb begin
      lit_c = '0;
      case (Q)
         4'd0:    lit_c = 7'b1111110;
         4'd1:    lit_c = 7'b0110000;
         4'd2:    lit_c = 7'b1101101;
         4'd3:    lit_c = 7'b1111001;
         4'd4:    lit_c = 7'b0110011;
         4'd5:    lit_c = 7'b1011011;
         4'd6:    lit_c = 7'b1011111;
         4'd7:    lit_c = 7'b1110000;
         4'd8:    lit_c = 7'b1111111;
         4'd9:    lit_c = 7'b1111011;
         default: lit_c = '0;
      endcase
      if (blank_c) begin
         lit_c = '0;
      end
   end

   // Apply display polarity (common anode lights on low).
   assign seg_c = SEG_ACTIVE_LOW ? ~lit_c : lit_c;
   assign {ADS, BDS, CDS, DDS, EDS, FDS, GDS} = seg_c;

endmodule
